// File: rtl/mvm_dp_pipe.sv
// mvm_dp_pipe: crossbar matrix-vector datapath with an on-chip weight store, zero-activation
// skipping and a ROW/MULT/ACC sequencer. Define MVM_DP_ACC_SAT_EN for sticky saturating sums.
module mvm_dp_pipe #(
    parameter int XBAR_SIZE = 4,
    parameter int IN_BITS   = 8,
    parameter int WT_BITS   = 8,
    parameter int MULT_BITS = 8,
    parameter int ACC_BITS  = 12
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            wt_wr_en,
    input  logic [$clog2(XBAR_SIZE)-1:0]    wt_wr_row,
    input  logic [XBAR_SIZE*WT_BITS-1:0]    wt_wr_data,
    output logic                            wt_wr_err,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [XBAR_SIZE*IN_BITS-1:0]    in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [XBAR_SIZE*ACC_BITS-1:0]   out_data,
    output logic [$clog2(XBAR_SIZE+1)-1:0]  skip_cnt,
    output logic                            busy
);
    localparam int RW = $clog2(XBAR_SIZE);
    localparam int SW = $clog2(XBAR_SIZE + 1);
    localparam int PW = IN_BITS + WT_BITS;

    typedef enum logic [2:0] {IDLE, ROW, MULT, ACC, DONE} state_t;

    state_t                       state_q, state_d;
    logic [RW-1:0]                row_q, row_d;
    logic [SW-1:0]                skip_q, skip_d;
    logic [XBAR_SIZE*IN_BITS-1:0] act_q;
    logic                         wt_err_q;
    logic                         load_act, clr_sums, rd_en, prod_en, acc_en, wt_we;
    logic [IN_BITS-1:0]           cur_act;
    logic                         last_row;

    logic [XBAR_SIZE*WT_BITS-1:0] wt_mem [XBAR_SIZE];
    logic [XBAR_SIZE*WT_BITS-1:0] rd_data_q;

    assign cur_act   = act_q[row_q*IN_BITS +: IN_BITS];
    assign last_row  = (row_q == RW'(XBAR_SIZE - 1));
    assign wt_we     = wt_wr_en && (state_q == IDLE || state_q == DONE);

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign skip_cnt  = skip_q;
    assign wt_wr_err = wt_err_q;

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        skip_d   = skip_q;
        load_act = 1'b0;
        clr_sums = 1'b0;
        rd_en    = 1'b0;
        prod_en  = 1'b0;
        acc_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load_act = 1'b1;
                    clr_sums = 1'b1;
                    skip_d   = '0;
                    row_d    = '0;
                    state_d  = ROW;
                end
            end
            ROW: begin
                if (cur_act == '0) begin
                    skip_d = skip_q + SW'(1);
                    if (last_row) state_d = DONE;
                    else          row_d   = row_q + RW'(1);
                end else begin
                    rd_en   = 1'b1;
                    state_d = MULT;
                end
            end
            MULT: begin
                prod_en = 1'b1;
                state_d = ACC;
            end
            ACC: begin
                acc_en = 1'b1;
                if (last_row) begin
                    state_d = DONE;
                end else begin
                    row_d   = row_q + RW'(1);
                    state_d = ROW;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            row_q    <= '0;
            skip_q   <= '0;
            act_q    <= '0;
            wt_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            skip_q   <= skip_d;
            wt_err_q <= wt_wr_en && !wt_we;
            if (load_act) act_q <= in_data;
        end
    end

    // Weight store is deliberately left out of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wt_we) wt_mem[wt_wr_row] <= wt_wr_data;
        if (rd_en) rd_data_q <= wt_mem[row_q];
    end

    for (genvar gi = 0; gi < XBAR_SIZE; gi++) begin : g_col
        logic [PW-1:0]        prod_full;
        logic [MULT_BITS-1:0] prod_q;
        logic [ACC_BITS-1:0]  sum_q, sum_d;

        assign prod_full = PW'(cur_act) * PW'(rd_data_q[gi*WT_BITS +: WT_BITS]);

`ifdef MVM_DP_ACC_SAT_EN
        logic                sat_q;
        logic [ACC_BITS:0]   sum_wide;

        assign sum_wide = {1'b0, sum_q} + (ACC_BITS+1)'(prod_q);
        assign sum_d    = (sat_q || sum_wide[ACC_BITS]) ? '1 : sum_wide[ACC_BITS-1:0];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)                          sat_q <= 1'b0;
            else if (clr_sums)                     sat_q <= 1'b0;
            else if (acc_en && sum_wide[ACC_BITS]) sat_q <= 1'b1;
        end
`else
        assign sum_d = sum_q + ACC_BITS'(prod_q);
`endif

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                prod_q <= '0;
                sum_q  <= '0;
            end else begin
                if (prod_en)       prod_q <= MULT_BITS'(prod_full >> (PW - MULT_BITS));
                if (clr_sums)      sum_q  <= '0;
                else if (acc_en)   sum_q  <= sum_d;
            end
        end

        assign out_data[gi*ACC_BITS +: ACC_BITS] = sum_q;
    end

endmodule

// File: tb/tb_mvm_dp_pipe.sv
// Directed bench for mvm_dp_pipe: vector table plus hand sequences for hold, reset and write-drop cases.
`timescale 1ns/1ps
module tb_mvm_dp_pipe;
    localparam int N  = 4;
    localparam int AB = 12;
    localparam int AB9 = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n;
    logic              wt_wr_en;
    logic [1:0]        wt_wr_row;
    logic [31:0]       wt_wr_data;
    logic              wt_wr_err;
    logic              in_valid, in_ready;
    logic [31:0]       in_data;
    logic              out_valid, out_ready;
    logic [N*AB-1:0]   out_data;
    logic [2:0]        skip_cnt;
    logic              busy;

    logic              b_wt_wr_en;
    logic [1:0]        b_wt_wr_row;
    logic [31:0]       b_wt_wr_data;
    logic              b_wt_wr_err;
    logic              b_in_valid, b_in_ready;
    logic [31:0]       b_in_data;
    logic              b_out_valid, b_out_ready;
    logic [N*AB9-1:0]  b_out_data;
    logic [2:0]        b_skip_cnt;
    logic              b_busy;

    mvm_dp_pipe #(.XBAR_SIZE(4), .IN_BITS(8), .WT_BITS(8), .MULT_BITS(8), .ACC_BITS(AB)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .wt_wr_en(wt_wr_en), .wt_wr_row(wt_wr_row), .wt_wr_data(wt_wr_data), .wt_wr_err(wt_wr_err),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .skip_cnt(skip_cnt), .busy(busy)
    );

    mvm_dp_pipe #(.XBAR_SIZE(4), .IN_BITS(8), .WT_BITS(8), .MULT_BITS(8), .ACC_BITS(AB9)) u_dut9 (
        .clk(clk), .reset_n(reset_n),
        .wt_wr_en(b_wt_wr_en), .wt_wr_row(b_wt_wr_row), .wt_wr_data(b_wt_wr_data), .wt_wr_err(b_wt_wr_err),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .skip_cnt(b_skip_cnt), .busy(b_busy)
    );

    typedef struct {
        string             name;
        logic [3:0][31:0]  wt;
        logic [31:0]       act;
        logic [3:0][11:0]  exp;
        int                skip;
        int                lat;
    } vec_t;

    vec_t tv[4];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic write_rows(input logic [3:0][31:0] w);
        for (int r = 0; r < 4; r++) begin
            wt_wr_en   = 1'b1;
            wt_wr_row  = 2'(r);
            wt_wr_data = w[r];
            @(posedge clk); #1;
        end
        wt_wr_en = 1'b0;
    endtask

    task automatic start_vec(input logic [31:0] a);
        in_valid = 1'b1;
        in_data  = a;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int start, output int lat);
        lat = -1;
        for (int k = start + 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [N*AB-1:0] held;

        tv[0].name = "all_nonzero";
        tv[0].wt   = {4{32'h10101010}};
        tv[0].act  = 32'h20202020;
        tv[0].exp  = {4{12'd8}};
        tv[0].skip = 0;  tv[0].lat = 12;

        tv[1].name = "all_zero";
        tv[1].wt   = {4{32'hFFFFFFFF}};
        tv[1].act  = 32'h00000000;
        tv[1].exp  = {4{12'd0}};
        tv[1].skip = 4;  tv[1].lat = 4;

        tv[2].name = "half_skip";
        tv[2].wt   = {32'h80808080, 32'h33333333, 32'h80808080, 32'h33333333};
        tv[2].act  = 32'h05000500;
        tv[2].exp  = {4{12'd4}};
        tv[2].skip = 2;  tv[2].lat = 8;

        tv[3].name  = "mixed";
        tv[3].wt[0] = 32'h80402010;
        tv[3].wt[1] = 32'hFFFFFFFF;
        tv[3].wt[2] = 32'h08040201;
        tv[3].wt[3] = 32'h12345678;
        tv[3].act   = 32'h00FF0180;
        tv[3].exp   = {12'h047, 12'h023, 12'h011, 12'h008};
        tv[3].skip  = 1; tv[3].lat = 10;

        reset_n = 1'b0;
        wt_wr_en = 1'b0; wt_wr_row = '0; wt_wr_data = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        b_wt_wr_en = 1'b0; b_wt_wr_row = '0; b_wt_wr_data = '0;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_wt_wr_err", 64'(wt_wr_err), 64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_skip_cnt",  64'(skip_cnt),  64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready",  64'(in_ready),  64'd1);

        for (int i = 0; i < 4; i++) begin
            write_rows(tv[i].wt);
            start_vec(tv[i].act);
            wait_done(0, lat);
            chk({tv[i].name, "_latency"}, 64'(lat), 64'(tv[i].lat));
            chk({tv[i].name, "_skip"}, 64'(skip_cnt), 64'(tv[i].skip));
            for (int c = 0; c < 4; c++)
                chk($sformatf("%s_col%0d", tv[i].name, c), 64'(out_data[c*AB +: AB]), 64'(tv[i].exp[c]));
            $display("vec %s: latency=%0d skip=%0d out_data=0x%012h", tv[i].name, lat, skip_cnt, out_data);
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            chk({tv[i].name, "_drop_valid"}, 64'(out_valid), 64'd0);
            chk({tv[i].name, "_in_ready"},   64'(in_ready),  64'd1);
        end

        // Output hold in DONE, with a weight write that must not disturb out_data.
        write_rows({4{32'h10101010}});
        start_vec(32'h20202020);
        wait_done(0, lat);
        chk("hold_latency", 64'(lat), 64'd12);
        held = out_data;
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                wt_wr_en = 1'b1; wt_wr_row = 2'd0; wt_wr_data = 32'h80808080;
            end
            @(posedge clk); #1;
            wt_wr_en = 1'b0;
            chk($sformatf("hold%0d_valid", k), 64'(out_valid), 64'd1);
            chk($sformatf("hold%0d_data", k),  64'(out_data),  64'h008008008008);
            chk($sformatf("hold%0d_skip", k),  64'(skip_cnt),  64'd0);
            chk($sformatf("hold%0d_in_ready", k), 64'(in_ready), 64'd0);
            chk($sformatf("hold%0d_wr_err", k),   64'(wt_wr_err), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("hold_exit_busy",  64'(busy),      64'd0);
        chk("hold_exit_valid", 64'(out_valid), 64'd0);
        chk("hold_exit_data",  64'(out_data),  64'(held));
        $display("vec hold: latency=%0d out_data=0x%012h", lat, held);

        // The row-0 write made in DONE is visible to the next vector.
        start_vec(32'h00000020);
        wait_done(0, lat);
        chk("newwt_latency", 64'(lat), 64'd6);
        chk("newwt_skip",    64'(skip_cnt), 64'd3);
        chk("newwt_data",    64'(out_data), 64'h010010010010);
        $display("vec newwt: latency=%0d skip=%0d out_data=0x%012h", lat, skip_cnt, out_data);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset while in MULT of row 1 abandons the vector.
        write_rows({4{32'h10101010}});
        start_vec(32'h20202020);
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_pre_data", 64'(out_data), 64'h002002002002);
        chk("midrst_pre_busy", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_busy",  64'(busy),      64'd0);
        chk("midrst_data",  64'(out_data),  64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_no_output", 64'(out_valid), 64'd0);
        chk("midrst_in_ready",  64'(in_ready),  64'd1);
        $display("vec midrst: abandoned, out_data=0x%012h", out_data);

        // A weight write during ACC is dropped and flagged.
        start_vec(32'h20202020);
        repeat (2) @(posedge clk);
        #1;
        wt_wr_en = 1'b1; wt_wr_row = 2'd0; wt_wr_data = 32'hFFFFFFFF;
        @(posedge clk); #1;
        wt_wr_en = 1'b0;
        chk("acc_wr_err_pulse", 64'(wt_wr_err), 64'd1);
        @(posedge clk); #1;
        chk("acc_wr_err_clear", 64'(wt_wr_err), 64'd0);
        wait_done(4, lat);
        chk("accwr_latency", 64'(lat), 64'd12);
        chk("accwr_data",    64'(out_data), 64'h008008008008);
        $display("vec accwr: latency=%0d out_data=0x%012h", lat, out_data);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Narrow accumulator: 4 * 0xFE overflows 9 bits.
        for (int r = 0; r < 4; r++) begin
            b_wt_wr_en = 1'b1; b_wt_wr_row = 2'(r); b_wt_wr_data = 32'hFFFFFFFF;
            @(posedge clk); #1;
        end
        b_wt_wr_en = 1'b0;
        b_in_valid = 1'b1; b_in_data = 32'hFFFFFFFF;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (b_out_valid) begin
                lat = k;
                break;
            end
        end
        chk("acc9_latency", 64'(lat), 64'd12);
        for (int c = 0; c < 4; c++)
`ifdef MVM_DP_ACC_SAT_EN
            chk($sformatf("acc9_col%0d", c), 64'(b_out_data[c*AB9 +: AB9]), 64'd511);
`else
            chk($sformatf("acc9_col%0d", c), 64'(b_out_data[c*AB9 +: AB9]), 64'd504);
`endif
        $display("vec acc9: latency=%0d out_data=0x%09h", lat, b_out_data);
        b_out_ready = 1'b1;
        @(posedge clk); #1;
        b_out_ready = 1'b0;
        chk("acc9_drop_valid", 64'(b_out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
